// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-bank write-back arbiter.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 16;

    // One register-bank write port beat.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_port_t;

    // One buffered load return.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LOAD = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer/issue-side bundle and register-bank write port of the write-back arbiter.
interface writeback_arbiter_if #(
    parameter int DATA_W   = writeback_arbiter_pkg::DATA_W,
    parameter int NUM_REGS = writeback_arbiter_pkg::NUM_REGS
);
    import writeback_arbiter_pkg::*;

    logic                  Alu_Valid;
    logic                  Alu_Ready;
    logic [REG_ADDR_W-1:0] Alu_Dest;
    logic [DATA_W-1:0]     Alu_Data;
    logic                  Load_Issue;
    logic [REG_ADDR_W-1:0] Load_Issue_Dest;
    logic                  Load_Valid;
    logic                  Load_Ready;
    logic [REG_ADDR_W-1:0] Load_Dest;
    logic [DATA_W-1:0]     Load_Data;
    logic                  Write_Enable;
    logic [REG_ADDR_W-1:0] Destination;
    logic [DATA_W-1:0]     LDR_MUX;
    logic [NUM_REGS-1:0]   Busy_Mask;

    modport slave (
        input  Alu_Valid, Alu_Dest, Alu_Data,
        input  Load_Issue, Load_Issue_Dest,
        input  Load_Valid, Load_Dest, Load_Data,
        output Alu_Ready, Load_Ready,
        output Write_Enable, Destination, LDR_MUX, Busy_Mask
    );

    modport master (
        output Alu_Valid, Alu_Dest, Alu_Data,
        output Load_Issue, Load_Issue_Dest,
        output Load_Valid, Load_Dest, Load_Data,
        input  Alu_Ready, Load_Ready,
        input  Write_Enable, Destination, LDR_MUX, Busy_Mask
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: in-order synchronous FIFO for load returns; DEPTH must be a power of two
// so the pointers wrap by plain overflow.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-bank write-port master: arbitrates ALU results against buffered load
// returns and tracks outstanding loads per register.
module writeback_arbiter #(
    parameter int LOAD_FIFO_DEPTH = 2,
    parameter int NUM_REGS        = writeback_arbiter_pkg::NUM_REGS,
    parameter int DATA_W          = writeback_arbiter_pkg::DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    writeback_arbiter_if.slave bus
);
    import writeback_arbiter_pkg::*;

    localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH + 1);

    wb_entry_t           push_entry_s;
    wb_entry_t           head_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                has_room_s;
    wb_sel_e             sel_s;
    wb_port_t            wport_q, wport_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Both producers stall on a full FIFO so the head can drain ahead of the ALU.
    assign has_room_s     = (fifo_count_s < CNT_W'(LOAD_FIFO_DEPTH));
    assign bus.Alu_Ready  = has_room_s;
    assign bus.Load_Ready = has_room_s;

    assign push_entry_s = '{dest: bus.Load_Dest, data: bus.Load_Data};
    assign push_s       = bus.Load_Valid && has_room_s;

    wb_fifo #(
        .DEPTH (LOAD_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wb_fifo (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .push_i  (push_s),
        .wdata_i (push_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Source selection: drain a full FIFO first, then ALU, then any buffered load.
    always_comb begin
        sel_s = SEL_NONE;
        pop_s = 1'b0;
        if (fifo_full_s && !fifo_empty_s) begin
            sel_s = SEL_LOAD;
            pop_s = 1'b1;
        end else if (bus.Alu_Valid) begin
            sel_s = SEL_ALU;
            pop_s = 1'b0;
        end else if (!fifo_empty_s) begin
            sel_s = SEL_LOAD;
            pop_s = 1'b1;
        end else begin
            sel_s = SEL_NONE;
            pop_s = 1'b0;
        end
    end

    // Next write-port beat; address and data hold when no write is selected.
    always_comb begin
        wport_d    = wport_q;
        wport_d.we = 1'b0;
        case (sel_s)
            SEL_ALU:  wport_d = '{we: 1'b1, dest: bus.Alu_Dest, data: bus.Alu_Data};
            SEL_LOAD: wport_d = '{we: 1'b1, dest: head_s.dest, data: head_s.data};
            default:  wport_d.we = 1'b0;
        endcase
    end

    // Pending-load scoreboard; a same-cycle issue overrides the write-back clear.
    always_comb begin
        busy_d = busy_q;
        if (pop_s) begin
            busy_d[head_s.dest] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (bus.Load_Issue) begin
            busy_d[bus.Load_Issue_Dest] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wport_q <= '0;
            busy_q  <= {NUM_REGS{1'b0}};
        end else begin
            wport_q <= wport_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Write_Enable = wport_q.we;
    assign bus.Destination  = wport_q.dest;
    assign bus.LDR_MUX      = wport_q.data;
    assign bus.Busy_Mask    = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.DATA_W(32), .NUM_REGS(16)) bus ();

    writeback_arbiter #(
        .LOAD_FIFO_DEPTH (DEPTH),
        .NUM_REGS        (16),
        .DATA_W          (32)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending load returns plus a busy vector.
    logic [35:0] mq [$];
    logic [35:0] wlog [$];
    logic [35:0] m_e;
    logic [15:0] m_busy = 16'h0000;
    logic        m_we   = 1'b0;
    logic [3:0]  m_dest = 4'd0;
    logic [31:0] m_data = 32'd0;
    bit          m_full;
    bit          cmp_en = 1'b0;

    // Once per cycle: check this cycle's outputs, then advance the model with the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_we",     bus.Write_Enable, m_we);
            chk("cyc_dest",   bus.Destination,  m_dest);
            chk("cyc_data",   bus.LDR_MUX,      m_data);
            chk("cyc_busy",   bus.Busy_Mask,    m_busy);
            chk("cyc_alurdy", bus.Alu_Ready,    (mq.size() < DEPTH));
            chk("cyc_ldrdy",  bus.Load_Ready,   (mq.size() < DEPTH));
            if (bus.Write_Enable === 1'b1) wlog.push_back({bus.Destination, bus.LDR_MUX});
        end
        if (rst) begin
            mq.delete();
            m_busy = 16'h0000;
            m_we   = 1'b0;
            m_dest = 4'd0;
            m_data = 32'd0;
        end else begin
            m_full = (mq.size() == DEPTH);
            if (mq.size() != 0 && (m_full || !bus.Alu_Valid)) begin
                m_e = mq.pop_front();
                m_we = 1'b1;
                m_dest = m_e[35:32];
                m_data = m_e[31:0];
                m_busy[m_dest] = 1'b0;
            end else if (bus.Alu_Valid) begin
                m_we = 1'b1;
                m_dest = bus.Alu_Dest;
                m_data = bus.Alu_Data;
            end else begin
                m_we = 1'b0;
            end
            if (bus.Load_Valid && !m_full) mq.push_back({bus.Load_Dest, bus.Load_Data});
            if (bus.Load_Issue) m_busy[bus.Load_Issue_Dest] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  ld_dest [3];
    logic [31:0] ld_data [3];
    logic [35:0] lq [$];
    int          li;
    int          n_alu;
    logic [31:0] last_alu;

    initial begin
        bus.Alu_Valid = 1'b0; bus.Alu_Dest = 4'd0; bus.Alu_Data = 32'd0;
        bus.Load_Issue = 1'b0; bus.Load_Issue_Dest = 4'd0;
        bus.Load_Valid = 1'b0; bus.Load_Dest = 4'd0; bus.Load_Data = 32'd0;
        ld_dest[0] = 4'd7; ld_dest[1] = 4'd8; ld_dest[2] = 4'd9;
        ld_data[0] = 32'h0000_7007; ld_data[1] = 32'h0000_8008; ld_data[2] = 32'h0000_9009;

        rst = 1'b1; tick(); tick(); rst = 1'b0; cmp_en = 1'b1;
        chk("rst_we", bus.Write_Enable, 1'b0);
        chk("rst_dest", bus.Destination, 4'd0);
        chk("rst_data", bus.LDR_MUX, 32'd0);
        chk("rst_busy", bus.Busy_Mask, 16'h0000);
        chk("rst_ready", {bus.Alu_Ready, bus.Load_Ready}, 2'b11);

        // Single ALU write
        bus.Alu_Valid = 1'b1; bus.Alu_Dest = 4'd3; bus.Alu_Data = 32'h0000_00AA;
        tick(); bus.Alu_Valid = 1'b0;
        chk("alu_we", bus.Write_Enable, 1'b1);
        chk("alu_dest", bus.Destination, 4'd3);
        chk("alu_data", bus.LDR_MUX, 32'h0000_00AA);
        tick();
        chk("alu_we_drop", bus.Write_Enable, 1'b0);
        chk("alu_dest_hold", bus.Destination, 4'd3);

        // Load issue, return, two-cycle strobe latency, busy clear
        bus.Load_Issue = 1'b1; bus.Load_Issue_Dest = 4'd5; tick(); bus.Load_Issue = 1'b0;
        chk("issue_busy", bus.Busy_Mask, 16'h0020);
        bus.Load_Valid = 1'b1; bus.Load_Dest = 4'd5; bus.Load_Data = 32'hDEAD_BEEF;
        tick(); bus.Load_Valid = 1'b0;
        chk("ld_lat_we0", bus.Write_Enable, 1'b0);
        chk("ld_lat_busy", bus.Busy_Mask, 16'h0020);
        tick();
        chk("ld_we", bus.Write_Enable, 1'b1);
        chk("ld_dest", bus.Destination, 4'd5);
        chk("ld_data", bus.LDR_MUX, 32'hDEAD_BEEF);
        chk("ld_busy_clr", bus.Busy_Mask, 16'h0000);
        tick();

        // ALU streaming while three loads arrive
        wlog.delete(); li = 0;
        bus.Alu_Valid = 1'b1; bus.Alu_Dest = 4'd1; bus.Alu_Data = 32'h0000_0100;
        bus.Load_Valid = 1'b1; bus.Load_Dest = ld_dest[0]; bus.Load_Data = ld_data[0];
        for (int c = 0; c < 10; c++) begin
            bit a_acc;
            bit l_acc;
            a_acc = bus.Alu_Valid && bus.Alu_Ready;
            l_acc = bus.Load_Valid && bus.Load_Ready;
            tick();
            if (c == 1) begin
                chk("full_alu_rdy", bus.Alu_Ready, 1'b0);
                chk("full_ld_rdy", bus.Load_Ready, 1'b0);
            end
            if (c == 2) begin
                chk("drain_we", bus.Write_Enable, 1'b1);
                chk("drain_dest", bus.Destination, 4'd7);
            end
            if (a_acc) bus.Alu_Data = bus.Alu_Data + 32'd1;
            if (l_acc) begin
                li++;
                if (li < 3) begin
                    bus.Load_Dest = ld_dest[li]; bus.Load_Data = ld_data[li];
                end else begin
                    bus.Load_Valid = 1'b0;
                end
            end
            if (c == 7) bus.Alu_Valid = 1'b0;
        end
        n_alu = 0; lq.delete(); last_alu = 32'd0;
        foreach (wlog[i]) begin
            if (wlog[i][35:32] == 4'd1) begin
                n_alu++; last_alu = wlog[i][31:0];
            end else if (wlog[i][35:32] >= 4'd7 && wlog[i][35:32] <= 4'd9) begin
                lq.push_back(wlog[i]);
            end
        end
        chk("mix_n_alu", n_alu, 6);
        chk("mix_last_alu", last_alu, 32'h0000_0105);
        chk("mix_n_load", lq.size(), 3);
        for (int i = 0; i < 3; i++) chk("mix_load_order", lq[i], {ld_dest[i], ld_data[i]});

        // Same-register set and clear in one cycle
        bus.Load_Issue = 1'b1; bus.Load_Issue_Dest = 4'd4; tick(); bus.Load_Issue = 1'b0;
        bus.Load_Valid = 1'b1; bus.Load_Dest = 4'd4; bus.Load_Data = 32'h0000_4444;
        tick(); bus.Load_Valid = 1'b0;
        bus.Load_Issue = 1'b1; bus.Load_Issue_Dest = 4'd4; tick(); bus.Load_Issue = 1'b0;
        chk("setwins_we", bus.Write_Enable, 1'b1);
        chk("setwins_dest", bus.Destination, 4'd4);
        chk("setwins_busy", bus.Busy_Mask, 16'h0010);

        // Reset with two loads buffered
        rst = 1'b1; tick(); rst = 1'b0;
        bus.Load_Issue = 1'b1; bus.Load_Issue_Dest = 4'd8; tick();
        bus.Load_Issue_Dest = 4'd9;
        bus.Alu_Valid = 1'b1; bus.Alu_Dest = 4'd2; bus.Alu_Data = 32'h0000_0022;
        bus.Load_Valid = 1'b1; bus.Load_Dest = 4'd8; bus.Load_Data = 32'h0000_8888;
        tick();
        bus.Load_Issue = 1'b0; bus.Load_Dest = 4'd9; bus.Load_Data = 32'h0000_9999;
        tick();
        bus.Load_Valid = 1'b0; bus.Alu_Valid = 1'b0;
        chk("pre_rst_busy", bus.Busy_Mask, 16'h0300);
        chk("pre_rst_ldrdy", bus.Load_Ready, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid_we", bus.Write_Enable, 1'b0);
        chk("rstmid_busy", bus.Busy_Mask, 16'h0000);
        chk("rstmid_ldrdy", bus.Load_Ready, 1'b1);
        wlog.delete();
        repeat (4) tick();
        chk("rstmid_no_stale", wlog.size(), 0);

        // Back-to-back loads: simultaneous push/pop, pointer wrap
        for (int i = 0; i < 10; i++) begin
            bus.Load_Valid = 1'b1;
            bus.Load_Dest = 4'(i + 10);
            bus.Load_Data = 32'hC0DE_0000 + 32'(i);
            tick();
            chk("wrap_ready", bus.Load_Ready, 1'b1);
        end
        bus.Load_Valid = 1'b0;
        repeat (3) tick();
        chk("wrap_count", wlog.size(), 10);
        for (int i = 0; i < 10; i++) chk("wrap_order", wlog[i], {4'(i + 10), 32'hC0DE_0000 + 32'(i)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side master for the 16 x 32-bit register bank. It drives the bank's write port (Destination, LDR_MUX, write enable) from two producers: the single-cycle ALU result path and the variable-latency load-return path.
- Load returns are buffered in a small FIFO. A per-register pending-load scoreboard lets issue logic stall reads of registers whose load has not yet written back.

Parameters:
- LOAD_FIFO_DEPTH, 2, number of buffered load-return entries (power of two, >= 2)
- NUM_REGS, 16, register count; sets Busy_Mask width
- DATA_W, 32, register data width

Ports:
- Clock  input  1  single system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Alu_Valid  input  1  ALU result present this cycle
- Alu_Ready  output  1  arbiter accepts the ALU result this cycle
- Alu_Dest  input  4  ALU destination register
- Alu_Data  input  DATA_W  ALU result
- Load_Issue  input  1  a load was issued this cycle; marks Load_Issue_Dest pending
- Load_Issue_Dest  input  4  destination register of the issued load
- Load_Valid  input  1  load-return data present
- Load_Ready  output  1  FIFO can accept a load return
- Load_Dest  input  4  load-return destination register
- Load_Data  input  DATA_W  load-return data
- Write_Enable  output  1  register bank write strobe (gates the decoder enables)
- Destination  output  4  register bank write address
- LDR_MUX  output  DATA_W  register bank write data
- Busy_Mask  output  NUM_REGS  bit i=1 while a load to register i is outstanding

Behaviour:
- Reset: Write_Enable=0, Destination=0, LDR_MUX=0, Busy_Mask=0, FIFO empty (count=0). Alu_Ready=1 and Load_Ready=1 from the first post-reset cycle.
- A reset mid-operation discards all buffered loads and all pending bits. No write is issued in the reset cycle.
- Handshakes: a transfer occurs on a cycle where Valid && Ready at the rising edge. Producers hold Dest and Data stable while Valid && !Ready.
- Load_Ready = (count < LOAD_FIFO_DEPTH). It is registered-state based, with no same-cycle pop-through when full.
- Alu_Ready = (count < LOAD_FIFO_DEPTH). When the FIFO is full, the ALU is stalled so the FIFO can drain (starvation guard).
- Arbitration each cycle, in priority order:
  (a) FIFO full and non-empty: pop the FIFO head.
  (b) Else if Alu_Valid: take the ALU result.
  (c) Else if FIFO non-empty: pop the FIFO head.
  (d) Else: no write.
- Output register: the selected source is captured at the edge. Next cycle Write_Enable=1, Destination and LDR_MUX = the selected dest/data. Write_Enable=0 otherwise; Destination and LDR_MUX hold their last values.
- Latency: ALU accept at edge N -> bank write strobe during cycle N+1. A load pushed at edge N -> earliest strobe during cycle N+2.
- FIFO: in-order. Simultaneous push and pop is legal (count unchanged). A push when full is impossible because Load_Ready=0. Read and write pointers wrap modulo LOAD_FIFO_DEPTH.
- Scoreboard:
  - A FIFO pop that writes register d clears Busy_Mask[d] at that edge.
  - Load_Issue sets Busy_Mask[Load_Issue_Dest] at the edge.
  - If set and clear hit the same register in the same cycle, set wins.
  - ALU writes never affect Busy_Mask.
- Ordering: an ALU write and a buffered load to the same register keep arbitration order. Preventing that WAW hazard is the issue logic's job, using Busy_Mask.

Decomposition:
- Shared package: REG_ADDR_W=4, DATA_W=32, NUM_REGS=16, and the write-port bundle typedef {we, dest[3:0], data[31:0]}.
- One sub-module: wb_fifo (parameterised synchronous FIFO).
  - Ports: push/pop, full/empty, count.
  - Entry: {dest, data}, width 36.

Test Plan:
- Reset then Alu_Valid=1, Alu_Dest=3, Alu_Data=0x0000_00AA for 1 cycle -> next cycle Write_Enable=1, Destination=3, LDR_MUX=0xAA; following cycle Write_Enable=0.
- Load_Issue dest=5 -> Busy_Mask=0x0020. Then Load_Valid dest=5 data=0xDEAD_BEEF with ALU idle -> strobe 2 cycles after push with LDR_MUX=0xDEADBEEF, and Busy_Mask=0x0000 after the pop edge.
- ALU valid every cycle (dest 1) while 3 loads arrive (dest 7,8,9) -> FIFO fills and Load_Ready=0, Alu_Ready=0 for one cycle, load 7 writes; all three loads eventually write in order 7,8,9 with no ALU result lost.
- Same cycle: FIFO pops dest=4 while Load_Issue dest=4 -> Busy_Mask[4] stays 1.
- Assert Reset with 2 entries buffered and Busy_Mask=0x0300 -> next cycle Write_Enable=0, Busy_Mask=0, Load_Ready=1, and no stale writes afterwards.
- Back-to-back loads with simultaneous push/pop over 10 cycles, depth 2 -> pointer wrap-around verified, data order preserved, count never exceeds 2.
